target_reach_monitor: RTL and testbench

- Parametrised N-axis successor to the motion-done checker in the FPGA controller.
- Captures a per-axis target, absolute or relative to the position at start, and scans live axis positions with one shared subtract/compare per cycle.
- Asserts at_target only after every axis stays within a programmable tolerance for SETTLE_SCANS consecutive full scans.
- Reports a timeout if the condition is not met in time; feeds the path-planner sequencer.

---
 rtl/target_reach_monitor.sv | 162 ++++++++++++++++
 tb/tb_target_reach_monitor.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/target_reach_monitor.sv
// target_reach_monitor: checks that N axes reach and settle on a target.
// One shared subtract/compare evaluates one axis per cycle. at_target is
// reported once SETTLE_SCANS consecutive full scans pass, or timed_out is
// reported once TIMEOUT cycles of scanning have elapsed.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no check in progress, all outputs low
// SCAN  | evaluating one axis per cycle, counting consecutive good scans
// DONE  | result valid (ready=1), at_target/timed_out/axis_in_tol held
module target_reach_monitor #(
    parameter int NAXES        = 2,
    parameter int WIDTH        = 32,
    parameter int SETTLE_SCANS = 3,
    parameter int TIMEOUT      = 4096
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   cancel,
    input  logic                   relative_target,
    input  logic [NAXES*WIDTH-1:0] target,
    input  logic [NAXES*WIDTH-1:0] current,
    input  logic [WIDTH-2:0]       thresh,
    output logic                   busy,
    output logic                   ready,
    output logic                   at_target,
    output logic                   timed_out,
    output logic [NAXES-1:0]       axis_in_tol
);

    localparam int IDX_W  = (NAXES > 1) ? $clog2(NAXES) : 1;
    localparam int PASS_W = (SETTLE_SCANS > 1) ? $clog2(SETTLE_SCANS) : 1;
    localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NAXES - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(SETTLE_SCANS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t              state;
    logic [WIDTH-1:0]    tgt [NAXES];
    logic [WIDTH-2:0]    thr;
    logic [IDX_W-1:0]    idx;
    logic [PASS_W-1:0]   pass_cnt;
    logic [TMR_W-1:0]    tmr;
    logic                scan_ok;

    logic [WIDTH-1:0]    cap_tgt [NAXES];
    logic [WIDTH-1:0]    tgt_sel;
    logic [WIDTH-1:0]    cur_sel;
    logic [WIDTH:0]      diff;
    logic [WIDTH:0]      mag;
    logic                ok;
    logic                last_axis;
    logic                success;
    logic                timeout_hit;

    // Signed add at WIDTH+1 bits, clamped to the signed WIDTH range.
    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] sum;
        sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (sum[WIDTH] != sum[WIDTH-1])
            return sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return sum[WIDTH-1:0];
    endfunction

    // Targets to latch on start: absolute, or offset from the live position.
    always_comb begin
        for (int i = 0; i < NAXES; i++) begin
            cap_tgt[i] = relative_target
                       ? sat_add(current[i*WIDTH +: WIDTH], target[i*WIDTH +: WIDTH])
                       : target[i*WIDTH +: WIDTH];
        end
    end

    // Shared evaluator for the axis selected by idx; one extra bit keeps
    // the difference exact so extreme positions cannot wrap to a pass.
    always_comb begin
        tgt_sel     = tgt[idx];
        cur_sel     = current[int'(idx)*WIDTH +: WIDTH];
        diff        = {tgt_sel[WIDTH-1], tgt_sel} - {cur_sel[WIDTH-1], cur_sel};
        mag         = diff[WIDTH] ? (~diff + 1'b1) : diff;
        ok          = (mag <= {2'b00, thr});
        last_axis   = (idx == IDX_LAST);
        success     = last_axis && scan_ok && ok && (pass_cnt == PASS_LAST);
        timeout_hit = (TIMEOUT != 0) && (tmr == TMR_LAST);
    end

    // Control FSM with registered outputs; cancel overrides everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            ready       <= 1'b0;
            at_target   <= 1'b0;
            timed_out   <= 1'b0;
            axis_in_tol <= '0;
            thr         <= '0;
            idx         <= '0;
            pass_cnt    <= '0;
            tmr         <= '0;
            scan_ok     <= 1'b0;
            for (int i = 0; i < NAXES; i++) tgt[i] <= '0;
        end else if (cancel) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            ready       <= 1'b0;
            at_target   <= 1'b0;
            timed_out   <= 1'b0;
            axis_in_tol <= '0;
            idx         <= '0;
            pass_cnt    <= '0;
            tmr         <= '0;
            scan_ok     <= 1'b0;
        end else if (state != S_SCAN) begin
            if (start) begin
                for (int i = 0; i < NAXES; i++) tgt[i] <= cap_tgt[i];
                thr       <= thresh;
                idx       <= '0;
                pass_cnt  <= '0;
                tmr       <= '0;
                scan_ok   <= 1'b1;
                state     <= S_SCAN;
                busy      <= 1'b1;
                ready     <= 1'b0;
                at_target <= 1'b0;
                timed_out <= 1'b0;
            end
        end else begin
            axis_in_tol[idx] <= ok;
            tmr              <= tmr + 1'b1;
            if (last_axis) begin
                idx     <= '0;
                scan_ok <= 1'b1;
                if (scan_ok && ok)
                    pass_cnt <= success ? '0 : pass_cnt + 1'b1;
                else
                    pass_cnt <= '0;
            end else begin
                idx     <= idx + 1'b1;
                scan_ok <= scan_ok & ok;
            end
            if (success) begin
                state     <= S_DONE;
                busy      <= 1'b0;
                ready     <= 1'b1;
                at_target <= 1'b1;
                timed_out <= 1'b0;
            end else if (timeout_hit) begin
                state     <= S_DONE;
                busy      <= 1'b0;
                ready     <= 1'b1;
                at_target <= 1'b0;
                timed_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_target_reach_monitor.sv
// Bench for target_reach_monitor: directed scenarios plus randomized trials,
// all checked against a scan-history reference model.
module tb_target_reach_monitor;

    localparam int NAXES   = 2;
    localparam int WIDTH   = 32;
    localparam int SETTLE  = 3;
    localparam int TIMEOUT = 64;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   start = 1'b0;
    logic                   cancel = 1'b0;
    logic                   relative_target = 1'b0;
    logic [NAXES*WIDTH-1:0] target = '0;
    logic [NAXES*WIDTH-1:0] current = '0;
    logic [WIDTH-2:0]       thresh = '0;
    logic                   busy, ready, at_target, timed_out;
    logic [NAXES-1:0]       axis_in_tol;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    target_reach_monitor #(
        .NAXES(NAXES), .WIDTH(WIDTH), .SETTLE_SCANS(SETTLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cancel(cancel),
        .relative_target(relative_target), .target(target), .current(current),
        .thresh(thresh), .busy(busy), .ready(ready), .at_target(at_target),
        .timed_out(timed_out), .axis_in_tol(axis_in_tol)
    );

    // Reference model: latched targets, cycles scanned, per-scan pass history.
    longint         m_tgt [NAXES];
    longint         m_thr;
    int             m_k;
    bit             m_hist [$];
    bit             m_scan_ok;
    bit             m_busy, m_ready, m_at, m_to;
    bit [NAXES-1:0] m_tol;

    function automatic logic [NAXES*WIDTH-1:0] pos2(longint x, longint y);
        logic [WIDTH-1:0] a, b;
        a = x[WIDTH-1:0];
        b = y[WIDTH-1:0];
        return {b, a};
    endfunction

    function automatic longint axis_val(logic [NAXES*WIDTH-1:0] v, int i);
        logic [WIDTH-1:0] s;
        s = v[i*WIDTH +: WIDTH];
        return longint'($signed(s));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NAXES; i++) m_tgt[i] = 0;
        m_thr = 0; m_k = 0; m_hist.delete(); m_scan_ok = 0;
        m_busy = 0; m_ready = 0; m_at = 0; m_to = 0; m_tol = '0;
    endtask

    // Predicts the outputs after the coming rising edge from the present inputs.
    task automatic model_edge();
        longint maxv, minv, s, d;
        int     ax;
        bit     ok, succ;
        maxv = (longint'(1) << (WIDTH-1)) - 1;
        minv = -(longint'(1) << (WIDTH-1));
        if (cancel) begin
            m_busy = 0; m_ready = 0; m_at = 0; m_to = 0; m_tol = '0;
        end else if (!m_busy && start) begin
            for (int i = 0; i < NAXES; i++) begin
                if (relative_target) begin
                    s = axis_val(current, i) + axis_val(target, i);
                    if (s > maxv) s = maxv;
                    if (s < minv) s = minv;
                end else begin
                    s = axis_val(target, i);
                end
                m_tgt[i] = s;
            end
            m_thr = longint'(thresh);
            m_k = 0; m_hist.delete(); m_scan_ok = 1;
            m_busy = 1; m_ready = 0; m_at = 0; m_to = 0;
        end else if (m_busy) begin
            ax = m_k % NAXES;
            d = m_tgt[ax] - axis_val(current, ax);
            if (d < 0) d = -d;
            ok = (d <= m_thr);
            m_tol[ax] = ok;
            m_scan_ok = m_scan_ok & ok;
            m_k++;
            succ = 0;
            if (ax == NAXES-1) begin
                m_hist.push_back(m_scan_ok);
                m_scan_ok = 1;
                if (m_hist.size() >= SETTLE) begin
                    succ = 1;
                    for (int j = 0; j < SETTLE; j++)
                        if (!m_hist[m_hist.size()-1-j]) succ = 0;
                end
            end
            if (succ) begin
                m_busy = 0; m_ready = 1; m_at = 1; m_to = 0;
            end else if (TIMEOUT != 0 && m_k == TIMEOUT) begin
                m_busy = 0; m_ready = 1; m_at = 0; m_to = 1;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        #3;
        checks++;
        if ({busy, ready, at_target, timed_out, axis_in_tol} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0", {busy, ready, at_target, timed_out, axis_in_tol});
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({busy, ready, at_target, timed_out, axis_in_tol} !== '0) begin
                errors++;
                $display("FAIL idle_outputs: got %b required 0", {busy, ready, at_target, timed_out, axis_in_tol});
            end
        end
    endtask

    task automatic test_absolute_boundary();
        relative_target = 1'b0;
        thresh = 100;
        target = pos2(1000, 2000);
        current = pos2(1050, 1900);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) step();
            checks++;
            if ({busy, ready} !== {1'(c < 6), 1'(c == 6)}) begin
                errors++;
                $display("FAIL abs_latency c=%0d: busy,ready got %b required %b", c, {busy, ready}, {1'(c < 6), 1'(c == 6)});
            end
        end
        checks++;
        if ({at_target, timed_out, axis_in_tol} !== 4'b1011) begin
            errors++;
            $display("FAIL abs_result: at,to,tol got %b required 1011", {at_target, timed_out, axis_in_tol});
        end
    endtask

    task automatic test_timeout();
        int n;
        current = pos2(1000, 2101);
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!ready && n < 200) begin
            step();
            n++;
            checks++;
            if ({busy, ready} !== {m_busy, m_ready}) begin
                errors++;
                $display("FAIL timeout_track n=%0d: got %b required %b", n, {busy, ready}, {m_busy, m_ready});
            end
        end
        checks++;
        if (n != TIMEOUT) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles required %0d", n, TIMEOUT);
        end
        checks++;
        if ({ready, at_target, timed_out, axis_in_tol} !== 5'b10101) begin
            errors++;
            $display("FAIL timeout_result: rdy,at,to,tol got %b required 10101", {ready, at_target, timed_out, axis_in_tol});
        end
    endtask

    task automatic test_relative();
        int n;
        relative_target = 1'b1;
        thresh = 10;
        current = pos2(500, -500);
        target = pos2(200, -300);
        start = 1'b1;
        step();
        start = 1'b0;
        relative_target = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (ready !== 1'b0) begin
                errors++;
                $display("FAIL relative_early c=%0d: ready got %b required 0", c, ready);
            end
        end
        current = pos2(700, -800);
        n = 0;
        while (!ready && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n != SETTLE*NAXES || at_target !== 1'b1) begin
            errors++;
            $display("FAIL relative_settle: cycles %0d at %b required %0d and 1", n, at_target, SETTLE*NAXES);
        end
    endtask

    task automatic test_settle_restart();
        relative_target = 1'b0;
        thresh = 100;
        target = pos2(1000, 2000);
        current = pos2(1000, 2000);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c == 5) current = pos2(1000, 2150);
            if (c == 7) current = pos2(1000, 2000);
            step();
            checks++;
            if ({ready, at_target} !== {2{1'(c == 12)}}) begin
                errors++;
                $display("FAIL settle_restart c=%0d: ready,at got %b required %b", c, {ready, at_target}, {2{1'(c == 12)}});
            end
        end
    endtask

    task automatic test_saturation();
        int n;
        relative_target = 1'b1;
        thresh = 0;
        current = pos2(64'h7FFFFFF0, 0);
        target = pos2(64'h100, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        current = pos2(64'h7FFFFFFF, 0);
        for (int c = 0; c < 6; c++) step();
        checks++;
        if ({ready, at_target, axis_in_tol} !== 4'b1111) begin
            errors++;
            $display("FAIL sat_relative: rdy,at,tol got %b required 1111", {ready, at_target, axis_in_tol});
        end
        relative_target = 1'b0;
        thresh = '1;
        target = pos2(64'h7FFFFFFF, 0);
        current = pos2(-64'sd2147483648, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!ready && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n != TIMEOUT || {at_target, timed_out, axis_in_tol} !== 4'b0110) begin
            errors++;
            $display("FAIL sat_extreme: cycles %0d at,to,tol %b required %0d 0110", n, {at_target, timed_out, axis_in_tol}, TIMEOUT);
        end
    endtask

    task automatic test_interrupts();
        relative_target = 1'b0;
        thresh = 100;
        target = pos2(1000, 2000);
        current = pos2(1050, 1900);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        checks++;
        if ({busy, ready, at_target, timed_out, axis_in_tol} !== '0) begin
            errors++;
            $display("FAIL cancel_outputs: got %b required 0", {busy, ready, at_target, timed_out, axis_in_tol});
        end
        start = 1'b1;
        cancel = 1'b1;
        step();
        start = 1'b0;
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel_beats_start: busy got %b required 0", busy);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({busy, ready, at_target, timed_out, axis_in_tol} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %b required 0", {busy, ready, at_target, timed_out, axis_in_tol});
        end
        @(negedge clk);
        reset_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 6; c++) step();
        current = pos2(1000, 2200);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({busy, ready, at_target, timed_out} !== 4'b1000) begin
            errors++;
            $display("FAIL restart_in_done: busy,rdy,at,to got %b required 1000", {busy, ready, at_target, timed_out});
        end
        checks++;
        if ({busy, ready, at_target, timed_out, axis_in_tol} !== {m_busy, m_ready, m_at, m_to, m_tol}) begin
            errors++;
            $display("FAIL restart_model: got %b required %b", {busy, ready, at_target, timed_out, axis_in_tol}, {m_busy, m_ready, m_at, m_to, m_tol});
        end
    endtask

    task automatic test_random();
        longint cv;
        int     thr, dev;
        for (int t = 0; t < 40; t++) begin
            relative_target = 1'($urandom_range(0, 1));
            thr = int'($urandom_range(0, 40));
            thresh = thr[WIDTH-2:0];
            for (int i = 0; i < NAXES; i++) begin
                cv = longint'(int'($urandom_range(0, 4000)) - 2000);
                target[i*WIDTH +: WIDTH] = cv[WIDTH-1:0];
                cv = longint'(int'($urandom_range(0, 4000)) - 2000);
                current[i*WIDTH +: WIDTH] = cv[WIDTH-1:0];
            end
            start = 1'b1;
            for (int c = 0; c < 90; c++) begin
                step();
                start = ($urandom_range(0, 7) == 0);
                cancel = ($urandom_range(0, 59) == 0);
                checks++;
                if ({busy, ready, at_target, timed_out, axis_in_tol} !== {m_busy, m_ready, m_at, m_to, m_tol}) begin
                    errors++;
                    $display("FAIL random t=%0d c=%0d: got %b required %b", t, c, {busy, ready, at_target, timed_out, axis_in_tol}, {m_busy, m_ready, m_at, m_to, m_tol});
                end
                for (int i = 0; i < NAXES; i++) begin
                    if ($urandom_range(0, 9) < 8)
                        dev = int'($urandom_range(0, 2*thr)) - thr;
                    else
                        dev = (thr + 1 + int'($urandom_range(0, 30))) * (($urandom_range(0, 1) == 1) ? 1 : -1);
                    cv = m_tgt[i] + longint'(dev);
                    current[i*WIDTH +: WIDTH] = cv[WIDTH-1:0];
                end
                if (!m_busy && c > 2) break;
            end
            start = 1'b0;
            cancel = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_absolute_boundary();
        test_timeout();
        test_relative();
        test_settle_restart();
        test_saturation();
        test_interrupts();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
